// File: rtl/dll_acq_ctrl.sv
// rtl/dll_acq_ctrl.sv - DLL acquisition/tracking sequencer owning the correlator code phase.
module dll_acq_ctrl #(
  parameter int unsigned           PHASE_W     = 16,
  parameter int unsigned           VAL_W       = 8,
  parameter logic [PHASE_W-1:0]    SEARCH_STEP = 16'h0800,
  parameter logic [PHASE_W-1:0]    TRACK_STEP  = 16'h0100,
  parameter int unsigned           DWELL       = 4,
  parameter int unsigned           CONFIRM_N   = 3,
  parameter int unsigned           ACQ_THRESH  = 96,
  parameter int unsigned           LOSS_THRESH = 48,
  parameter int unsigned           LOSS_COUNT  = 8,
  parameter int unsigned           DEADBAND    = 4
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               enable,
  input  logic [PHASE_W-1:0] start_phase,
  input  logic               corr_rdy,
  input  logic [VAL_W-1:0]   early,
  input  logic [VAL_W-1:0]   prompt,
  input  logic [VAL_W-1:0]   late,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_upd,
  output logic               lock,
  output logic [1:0]         state,
  output logic               sweep_done
);

  localparam int unsigned ACC_W = VAL_W + 4;
  localparam int unsigned DW_W  = $clog2(DWELL + 1);
  localparam int unsigned CF_W  = $clog2(CONFIRM_N + 1);
  localparam int unsigned MS_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [ACC_W-1:0] ACQ_SUM  = ACC_W'(ACQ_THRESH * DWELL);
  localparam logic [VAL_W-1:0] ACQ_TH   = VAL_W'(ACQ_THRESH);
  localparam logic [VAL_W-1:0] LOSS_TH  = VAL_W'(LOSS_THRESH);
  localparam logic [VAL_W:0]   DB       = (VAL_W+1)'(DEADBAND);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_CONFIRM = 2'd2,
    S_TRACK   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] origin_q, origin_d;
  logic               phase_upd_q, phase_upd_d;
  logic               lock_q, lock_d;
  logic               sweep_done_q, sweep_done_d;
  logic               settle_q, settle_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [CF_W-1:0]    conf_q, conf_d;
  logic [MS_W-1:0]    miss_q, miss_d;

  logic               accept;
  logic [ACC_W-1:0]   acc_sum;
  logic [DW_W-1:0]    dwell_inc;
  logic [CF_W-1:0]    conf_inc;
  logic [MS_W-1:0]    miss_nx;
  logic [PHASE_W-1:0] phase_step;
  logic               late_ge, early_ge;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      origin_q     <= '0;
      phase_upd_q  <= 1'b0;
      lock_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      settle_q     <= 1'b1;
      acc_q        <= '0;
      dwell_q      <= '0;
      conf_q       <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      origin_q     <= origin_d;
      phase_upd_q  <= phase_upd_d;
      lock_q       <= lock_d;
      sweep_done_q <= sweep_done_d;
      settle_q     <= settle_d;
      acc_q        <= acc_d;
      dwell_q      <= dwell_d;
      conf_q       <= conf_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    origin_d     = origin_q;
    phase_upd_d  = 1'b0;
    lock_d       = lock_q;
    sweep_done_d = 1'b0;
    settle_d     = settle_q;
    acc_d        = acc_q;
    dwell_d      = dwell_q;
    conf_d       = conf_q;
    miss_d       = miss_q;

    accept     = corr_rdy && !settle_q;
    acc_sum    = acc_q + ACC_W'(prompt);
    dwell_inc  = dwell_q + 1'b1;
    conf_inc   = conf_q + 1'b1;
    miss_nx    = (prompt < LOSS_TH) ? miss_q + 1'b1 : '0;
    phase_step = phase_q + SEARCH_STEP;
    late_ge    = {1'b0, late}  >= ({1'b0, early} + DB);
    early_ge   = {1'b0, early} >= ({1'b0, late} + DB);

    // The first result after a phase change integrated across the old phase.
    if (corr_rdy && settle_q) settle_d = 1'b0;

    if (!enable) begin
      state_d  = S_IDLE;
      lock_d   = 1'b0;
      settle_d = 1'b1;
      acc_d    = '0;
      dwell_d  = '0;
      conf_d   = '0;
      miss_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          phase_d     = start_phase;
          origin_d    = start_phase;
          phase_upd_d = 1'b1;
          settle_d    = 1'b1;
          state_d     = S_SEARCH;
        end
        S_SEARCH: begin
          if (accept) begin
            if (dwell_inc == DW_W'(DWELL)) begin
              acc_d    = '0;
              dwell_d  = '0;
              settle_d = 1'b1;
              if (acc_sum >= ACQ_SUM) begin
                state_d = S_CONFIRM;
                conf_d  = '0;
              end else begin
                phase_d      = phase_step;
                phase_upd_d  = 1'b1;
                sweep_done_d = (phase_step == origin_q);
              end
            end else begin
              acc_d   = acc_sum;
              dwell_d = dwell_inc;
            end
          end
        end
        S_CONFIRM: begin
          if (accept) begin
            if (prompt >= ACQ_TH) begin
              if (conf_inc == CF_W'(CONFIRM_N)) begin
                state_d  = S_TRACK;
                lock_d   = 1'b1;
                settle_d = 1'b1;
                conf_d   = '0;
                miss_d   = '0;
              end else begin
                conf_d = conf_inc;
              end
            end else begin
              state_d     = S_SEARCH;
              phase_d     = phase_step;
              phase_upd_d = 1'b1;
              settle_d    = 1'b1;
              conf_d      = '0;
              acc_d       = '0;
              dwell_d     = '0;
            end
          end
        end
        S_TRACK: begin
          if (accept) begin
            // Loss of lock wins over any early/late correction from the same result.
            if (miss_nx == MS_W'(LOSS_COUNT)) begin
              state_d     = S_SEARCH;
              lock_d      = 1'b0;
              phase_d     = phase_step;
              origin_d    = phase_step;
              phase_upd_d = 1'b1;
              settle_d    = 1'b1;
              miss_d      = '0;
              acc_d       = '0;
              dwell_d     = '0;
            end else begin
              miss_d = miss_nx;
              if (late_ge) begin
                phase_d     = phase_q + TRACK_STEP;
                phase_upd_d = 1'b1;
                settle_d    = 1'b1;
              end else if (early_ge) begin
                phase_d     = phase_q - TRACK_STEP;
                phase_upd_d = 1'b1;
                settle_d    = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign phase      = phase_q;
  assign phase_upd  = phase_upd_q;
  assign lock       = lock_q;
  assign state      = state_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_dll_acq_ctrl.sv
// tb/tb_dll_acq_ctrl.sv - randomized and directed bench for dll_acq_ctrl with a result-level model.
module tb_dll_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] start_phase = '0;
  logic        corr_rdy = 1'b0;
  logic [7:0]  early = '0, prompt = '0, late = '0;
  logic [15:0] phase;
  logic        phase_upd, lock, sweep_done;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int sd_cnt = 0;

  // Reference model: one step per correlator result, in plain integers.
  int          m_state, m_sum, m_dwell, m_conf, m_miss;
  logic [15:0] m_phase, m_origin;
  bit          m_settle, m_upd, m_sd;

  dll_acq_ctrl dut (
    .clk(clk), .rst_in(rst_in), .enable(enable), .start_phase(start_phase),
    .corr_rdy(corr_rdy), .early(early), .prompt(prompt), .late(late),
    .phase(phase), .phase_upd(phase_upd), .lock(lock), .state(state),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sweep_done) sd_cnt++;

  function automatic void model_clear();
    m_state = 0; m_sum = 0; m_dwell = 0; m_conf = 0; m_miss = 0;
    m_settle = 1; m_upd = 0; m_sd = 0;
  endfunction

  function automatic void model_step(int e, int p, int l);
    m_upd = 0; m_sd = 0;
    if (m_state == 0) return;
    if (m_settle) begin m_settle = 0; return; end
    case (m_state)
      1: begin
        m_sum += p; m_dwell++;
        if (m_dwell == 4) begin
          m_settle = 1;
          if (m_sum >= 96 * 4) begin m_state = 2; m_conf = 0; end
          else begin
            m_phase = m_phase + 16'h0800; m_upd = 1;
            m_sd = (m_phase == m_origin);
          end
          m_sum = 0; m_dwell = 0;
        end
      end
      2: begin
        if (p >= 96) begin
          m_conf++;
          if (m_conf == 3) begin m_state = 3; m_settle = 1; m_miss = 0; m_conf = 0; end
        end else begin
          m_state = 1; m_phase = m_phase + 16'h0800; m_upd = 1; m_settle = 1;
          m_sum = 0; m_dwell = 0; m_conf = 0;
        end
      end
      default: begin
        m_miss = (p < 48) ? m_miss + 1 : 0;
        if (m_miss == 8) begin
          m_state = 1; m_phase = m_phase + 16'h0800; m_origin = m_phase;
          m_upd = 1; m_settle = 1; m_miss = 0; m_sum = 0; m_dwell = 0;
        end else if (l >= e + 4) begin
          m_phase = m_phase + 16'h0100; m_upd = 1; m_settle = 1;
        end else if (e >= l + 4) begin
          m_phase = m_phase - 16'h0100; m_upd = 1; m_settle = 1;
        end
      end
    endcase
  endfunction

  task automatic rdy(input logic [7:0] e, input logic [7:0] p, input logic [7:0] l);
    @(negedge clk);
    early = e; prompt = p; late = l; corr_rdy = 1'b1;
    @(negedge clk);
    corr_rdy = 1'b0;
    model_step(int'(e), int'(p), int'(l));
  endtask

  task automatic stop();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    model_clear();
  endtask

  task automatic start(input logic [15:0] sp);
    @(negedge clk);
    enable = 1'b1; start_phase = sp;
    @(negedge clk);
    model_clear();
    m_state = 1; m_phase = sp; m_origin = sp; m_upd = 1;
  endtask

  task automatic acquire(input logic [15:0] sp);
    stop();
    start(sp);
    for (int i = 0; i < 9; i++) rdy(8'd90, 8'd120, 8'd90);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (phase !== 16'h0) begin errors++; $display("FAIL reset_phase got %h exp 0000", phase); end
    checks++; if (state !== 2'd0 || lock !== 1'b0) begin errors++; $display("FAIL reset_state got state=%0d lock=%0d exp 0/0", state, lock); end
    checks++; if (phase_upd !== 1'b0 || sweep_done !== 1'b0) begin errors++; $display("FAIL reset_pulses got upd=%0d sd=%0d exp 0/0", phase_upd, sweep_done); end
    rst_in = 1'b1;
    model_clear(); m_phase = 16'h0;
  endtask

  task automatic test_sweep();
    stop();
    start(16'h0000);
    checks++; if (phase !== 16'h0000 || phase_upd !== 1'b1) begin errors++; $display("FAIL sweep_start got phase=%h upd=%0d exp 0000/1", phase, phase_upd); end
    sd_cnt = 0;
    for (int b = 0; b < 32; b++) begin
      for (int k = 0; k < 5; k++) begin
        rdy(8'd0, 8'd10, 8'd0);
        checks++;
        if (phase !== m_phase || phase_upd !== m_upd || sweep_done !== m_sd || state !== 2'(m_state)) begin
          errors++;
          $display("FAIL sweep_step bin=%0d got phase=%h upd=%0d sd=%0d st=%0d exp %h/%0d/%0d/%0d",
                   b, phase, phase_upd, sweep_done, state, m_phase, m_upd, m_sd, m_state);
        end
      end
    end
    @(negedge clk);
    checks++; if (phase !== 16'h0000) begin errors++; $display("FAIL sweep_end_phase got %h exp 0000", phase); end
    checks++; if (sd_cnt !== 1) begin errors++; $display("FAIL sweep_done_count got %0d exp 1", sd_cnt); end
  endtask

  task automatic test_acquire();
    stop();
    start(16'h3000);
    for (int i = 0; i < 5; i++) rdy(8'd90, 8'd120, 8'd90);
    checks++; if (state !== 2'd2 || phase !== 16'h3000 || phase_upd !== 1'b0) begin errors++; $display("FAIL acq_confirm got st=%0d phase=%h upd=%0d exp 2/3000/0", state, phase, phase_upd); end
    for (int i = 0; i < 4; i++) rdy(8'd90, 8'd120, 8'd90);
    checks++; if (state !== 2'd3 || lock !== 1'b1 || phase !== 16'h3000) begin errors++; $display("FAIL acq_lock got st=%0d lock=%0d phase=%h exp 3/1/3000", state, lock, phase); end
  endtask

  task automatic test_confirm_fail();
    stop();
    start(16'h3000);
    for (int i = 0; i < 6; i++) rdy(8'd90, 8'd120, 8'd90);
    rdy(8'd90, 8'd50, 8'd90);
    checks++; if (phase !== 16'h3800 || state !== 2'd1 || lock !== 1'b0 || phase_upd !== 1'b1) begin errors++; $display("FAIL confirm_fail got phase=%h st=%0d lock=%0d upd=%0d exp 3800/1/0/1", phase, state, lock, phase_upd); end
  endtask

  task automatic test_tracking();
    acquire(16'h3000);
    rdy(8'd90, 8'd120, 8'd90);
    rdy(8'd100, 8'd120, 8'd80);
    checks++; if (phase !== 16'h2F00 || phase_upd !== 1'b1) begin errors++; $display("FAIL track_early got phase=%h upd=%0d exp 2f00/1", phase, phase_upd); end
    rdy(8'd100, 8'd120, 8'd80);
    checks++; if (phase !== 16'h2F00 || phase_upd !== 1'b0) begin errors++; $display("FAIL track_settle got phase=%h upd=%0d exp 2f00/0", phase, phase_upd); end
    rdy(8'd90, 8'd120, 8'd90);
    checks++; if (phase !== 16'h2F00 || phase_upd !== 1'b0) begin errors++; $display("FAIL track_hold got phase=%h upd=%0d exp 2f00/0", phase, phase_upd); end
    rdy(8'd90, 8'd120, 8'd95);
    checks++; if (phase !== 16'h3000 || phase_upd !== 1'b1) begin errors++; $display("FAIL track_late got phase=%h upd=%0d exp 3000/1", phase, phase_upd); end
    rdy(8'd90, 8'd120, 8'd90);
    rdy(8'd90, 8'd120, 8'd93);
    checks++; if (phase !== 16'h3000 || phase_upd !== 1'b0) begin errors++; $display("FAIL track_deadband got phase=%h upd=%0d exp 3000/0", phase, phase_upd); end
  endtask

  task automatic test_loss_wrap();
    acquire(16'h0000);
    rdy(8'd90, 8'd120, 8'd90);
    rdy(8'd110, 8'd120, 8'd100);
    checks++; if (phase !== 16'hFF00) begin errors++; $display("FAIL wrap_down got %h exp ff00", phase); end
    acquire(16'hFF80);
    rdy(8'd90, 8'd120, 8'd90);
    rdy(8'd100, 8'd120, 8'd110);
    checks++; if (phase !== 16'h0080) begin errors++; $display("FAIL wrap_up got %h exp 0080", phase); end
    rdy(8'd90, 8'd20, 8'd90);
    for (int i = 0; i < 7; i++) rdy(8'd90, 8'd20, 8'd90);
    checks++; if (lock !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL loss_early got lock=%0d st=%0d exp 1/3", lock, state); end
    rdy(8'd80, 8'd20, 8'd100);
    checks++; if (lock !== 1'b0 || state !== 2'd1 || phase !== 16'h0880) begin errors++; $display("FAIL loss got lock=%0d st=%0d phase=%h exp 0/1/0880", lock, state, phase); end
  endtask

  task automatic test_abort();
    acquire(16'h5000);
    rdy(8'd90, 8'd120, 8'd90);
    @(negedge clk);
    enable = 1'b0; corr_rdy = 1'b1; early = 8'd50; late = 8'd120; prompt = 8'd120;
    @(negedge clk);
    corr_rdy = 1'b0;
    model_clear();
    checks++; if (state !== 2'd0 || lock !== 1'b0 || phase !== 16'h5000 || phase_upd !== 1'b0) begin errors++; $display("FAIL abort got st=%0d lock=%0d phase=%h upd=%0d exp 0/0/5000/0", state, lock, phase, phase_upd); end
  endtask

  task automatic test_reset_mid();
    acquire(16'h3000);
    #3 rst_in = 1'b0;
    #1;
    checks++; if (phase !== 16'h0 || lock !== 1'b0 || state !== 2'd0 || phase_upd !== 1'b0) begin errors++; $display("FAIL reset_mid got phase=%h lock=%0d st=%0d upd=%0d exp 0000/0/0/0", phase, lock, state, phase_upd); end
    @(negedge clk);
    enable = 1'b0;
    rst_in = 1'b1;
    model_clear();
    start(16'h1234);
    checks++; if (phase !== 16'h1234 || phase_upd !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL restart got phase=%h upd=%0d st=%0d exp 1234/1/1", phase, phase_upd, state); end
    @(negedge clk);
    checks++; if (phase_upd !== 1'b0) begin errors++; $display("FAIL restart_pulse got upd=%0d exp 0", phase_upd); end
  endtask

  task automatic test_random();
    int li, e, p;
    stop();
    start(16'($urandom));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        @(negedge clk);
        enable = 1'b0; corr_rdy = 1'b1; prompt = 8'($urandom);
        @(negedge clk);
        corr_rdy = 1'b0;
        model_clear();
        checks++; if (state !== 2'd0 || phase !== m_phase || lock !== 1'b0) begin errors++; $display("FAIL rand_abort got st=%0d phase=%h lock=%0d exp 0/%h/0", state, phase, lock, m_phase); end
        start(16'($urandom));
      end else begin
        p  = ($urandom_range(0, 2) != 0) ? int'($urandom_range(90, 255)) : int'($urandom_range(0, 255));
        e  = int'($urandom_range(0, 255));
        li = e + int'($urandom_range(0, 16)) - 8;
        if (li < 0) li = 0;
        if (li > 255) li = 255;
        rdy(8'(e), 8'(p), 8'(li));
        checks++;
        if (phase !== m_phase || state !== 2'(m_state) || lock !== (m_state == 3) ||
            phase_upd !== m_upd || sweep_done !== m_sd) begin
          errors++;
          $display("FAIL rand_step i=%0d got phase=%h st=%0d lock=%0d upd=%0d sd=%0d exp %h/%0d/%0d/%0d/%0d",
                   i, phase, state, lock, phase_upd, sweep_done, m_phase, m_state, (m_state == 3), m_upd, m_sd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_acquire();
    test_confirm_fail();
    test_tracking();
    test_loss_wrap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
